// File: rtl/sha256_block_ctrl.sv
// -----------------------------------------------------------------------------
// sha256_block_ctrl
//
// Sequencing controller for an external combinational SHA-256 round datapath.
// Holds the a..h working registers, steps the round index once per clock,
// performs the final per-word hash addition and keeps the chaining digest
// across consecutive message blocks.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   start       block request, accepted only while ready
//   first_block sampled with start: 1 = chain from IV, 0 = chain from digest
//   block_in    512-bit message block, W0 at [511:480]
//   ready       high in IDLE
//   busy        high in ROUND and FINAL
//   done        one-cycle pulse after the digest has been updated
//   digest      H0..H7, H0 at [255:224]
//   rnd_j       round index to the datapath
//   rnd_data    latched message block to the datapath
//   rnd_state   working registers {a..h} to the datapath, a at [255:224]
//   rnd_next    datapath result {a..h} for the current round
// -----------------------------------------------------------------------------
module sha256_block_ctrl #(
  parameter int NUM_ROUNDS = 64,
  parameter int J_W        = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           first_block,
  input  logic [511:0]   block_in,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [255:0]   digest,
  output logic [J_W-1:0] rnd_j,
  output logic [511:0]   rnd_data,
  output logic [255:0]   rnd_state,
  input  logic [255:0]   rnd_next
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;

  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [J_W-1:0] LAST_J = J_W'(NUM_ROUNDS - 1);

  logic [1:0]   state;
  logic [255:0] hc;      // chaining value the current block started from
  logic [255:0] h_start; // value loaded into hc and the working regs at accept

  // Eight independent 32-bit modular adds; carries never cross word borders.
  function automatic logic [255:0] add_words(input logic [255:0] x,
                                             input logic [255:0] y);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[i*32 +: 32] = x[i*32 +: 32] + y[i*32 +: 32];
    end
    return r;
  endfunction

  assign ready   = (state == S_IDLE);
  assign busy    = (state == S_ROUND) || (state == S_FINAL);
  // Chaining from digest works for a start in the done cycle because digest
  // was already written at the FINAL edge.
  assign h_start = first_block ? IV : digest;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rnd_j     <= '0;
      rnd_state <= '0;
      rnd_data  <= '0;
      hc        <= IV;
      digest    <= IV;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            rnd_data  <= block_in;
            hc        <= h_start;
            rnd_state <= h_start;
            rnd_j     <= '0;
            state     <= S_ROUND;
          end
        end
        S_ROUND: begin
          rnd_state <= rnd_next;
          // rnd_j parks on the last index through FINAL.
          if (rnd_j == LAST_J) begin
            state <= S_FINAL;
          end else begin
            rnd_j <= rnd_j + J_W'(1);
          end
        end
        S_FINAL: begin
          digest <= add_words(hc, rnd_state);
          done   <= 1'b1;
          state  <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
